// File: rtl/scope_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : scope_capture_ctrl_if
// Description : Sample stream, control and status bundle for the capture
//               sequencer. The slave side is the sequencer itself.
// Revision    : 1.0
// ============================================================================
interface scope_capture_ctrl_if #(
  parameter int DWL = 8,
  parameter int AWL = 10
);
  logic [DWL-1:0] I_DIN;
  logic           I_DEN;
  logic           I_TRIG_ON;
  logic           I_ARM;
  logic           I_AUTO;
  logic           I_FORCE;
  logic           I_ABORT;
  logic           I_ACK;
  logic [AWL-1:0] I_PRE_LEN;
  logic           O_WR_EN;
  logic [AWL-1:0] O_WR_ADDR;
  logic [DWL-1:0] O_WR_DATA;
  logic [AWL-1:0] O_TRIG_ADDR;
  logic [AWL-1:0] O_START_ADDR;
  logic           O_DONE;
  logic           O_BUSY;
  logic [2:0]     O_STATE;
  logic [15:0]    O_CAP_CNT;

  modport master (
    output I_DIN, I_DEN, I_TRIG_ON, I_ARM, I_AUTO, I_FORCE, I_ABORT, I_ACK, I_PRE_LEN,
    input  O_WR_EN, O_WR_ADDR, O_WR_DATA, O_TRIG_ADDR, O_START_ADDR,
           O_DONE, O_BUSY, O_STATE, O_CAP_CNT
  );

  modport slave (
    input  I_DIN, I_DEN, I_TRIG_ON, I_ARM, I_AUTO, I_FORCE, I_ABORT, I_ACK, I_PRE_LEN,
    output O_WR_EN, O_WR_ADDR, O_WR_DATA, O_TRIG_ADDR, O_START_ADDR,
           O_DONE, O_BUSY, O_STATE, O_CAP_CNT
  );
endinterface
`default_nettype wire

// File: rtl/scope_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scope_capture_ctrl
// Description : Pre/post-trigger capture sequencer writing a circular sample
//               RAM and reporting trigger / oldest-sample addresses.
// Revision    : 1.0
// ============================================================================
module scope_capture_ctrl #(
  parameter int DWL = 8,
  parameter int AWL = 10
) (
  input  wire logic           I_CLK,
  input  wire logic           I_RST_N,
  scope_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [AWL:0]   c_DEPTH   = {1'b1, {AWL{1'b0}}};
  localparam logic [AWL:0]   c_ONE     = {{AWL{1'b0}}, 1'b1};
  localparam logic [AWL-1:0] c_PTR_ONE = {{(AWL-1){1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_nxt;
  logic [AWL-1:0] r_wr_ptr;
  logic [AWL-1:0] r_pre_len;
  logic [AWL:0]   r_post_len;
  logic [AWL:0]   r_cnt;
  logic [AWL:0]   w_cnt_nxt;
  logic           r_force_pend;
  logic           w_force_nxt;
  logic [AWL-1:0] r_trig_ptr;
  logic           r_wr_en;
  logic [AWL-1:0] r_wr_addr;
  logic [DWL-1:0] r_wr_data;
  logic [AWL-1:0] r_trig_addr;
  logic [AWL-1:0] r_start_addr;
  logic [15:0]    r_cap_cnt;

  logic           w_busy;
  logic           w_accept;
  logic           w_write;
  logic           w_trig;
  logic           w_load;
  logic           w_enter_done;
  logic [AWL-1:0] w_trig_ptr;

  assign w_busy   = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  assign w_accept = w_busy && bus.I_DEN;
  assign w_write  = w_accept && !bus.I_ABORT;
  assign w_trig   = (r_state == ST_WAIT) && w_accept && (bus.I_TRIG_ON || r_force_pend);

  // r_cnt counts pre-trigger samples in PRE and remaining samples in POST
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_force_nxt = r_force_pend;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.I_ARM) w_load = 1'b1;
      end
      ST_PRE: begin
        if (w_accept) begin
          if ((r_cnt + c_ONE) == {1'b0, r_pre_len}) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (bus.I_FORCE) w_force_nxt = 1'b1;
        if (w_trig) begin
          w_force_nxt = 1'b0;
          w_cnt_nxt   = r_post_len - c_ONE;
          w_state_nxt = (r_post_len == c_ONE) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt - c_ONE;
          if (r_cnt == c_ONE) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.I_ACK) begin
          if (bus.I_AUTO) w_load = 1'b1;
          else            w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (bus.I_PRE_LEN == '0) ? ST_WAIT : ST_PRE;
    end
    if (bus.I_ABORT) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
    end
    if (w_state_nxt != ST_WAIT) w_force_nxt = 1'b0;
  end

  assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
  // A capture with a one-sample post window reaches DONE on the trigger edge itself
  assign w_trig_ptr   = w_trig ? r_wr_ptr : r_trig_ptr;

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_wr_ptr     <= '0;
      r_pre_len    <= '0;
      r_post_len   <= '0;
      r_cnt        <= '0;
      r_force_pend <= 1'b0;
      r_trig_ptr   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_cap_cnt    <= '0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_force_pend <= w_force_nxt;
      r_wr_en      <= w_write;
      if (w_load) begin
        r_pre_len  <= bus.I_PRE_LEN;
        r_post_len <= c_DEPTH - {1'b0, bus.I_PRE_LEN};
        r_wr_ptr   <= '0;
      end else if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_write) begin
        r_wr_addr <= r_wr_ptr;
        r_wr_data <= bus.I_DIN;
      end
      if (w_trig && !bus.I_ABORT) r_trig_ptr <= r_wr_ptr;
      if (w_enter_done) begin
        r_trig_addr  <= w_trig_ptr;
        r_start_addr <= w_trig_ptr - r_pre_len;
        r_cap_cnt    <= r_cap_cnt + 16'd1;
      end
    end
  end

  assign bus.O_WR_EN      = r_wr_en;
  assign bus.O_WR_ADDR    = r_wr_addr;
  assign bus.O_WR_DATA    = r_wr_data;
  assign bus.O_TRIG_ADDR  = r_trig_addr;
  assign bus.O_START_ADDR = r_start_addr;
  assign bus.O_DONE       = (r_state == ST_DONE);
  assign bus.O_BUSY       = w_busy;
  assign bus.O_STATE      = r_state;
  assign bus.O_CAP_CNT    = r_cap_cnt;

endmodule
`default_nettype wire
